// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for one CNN pass: fetches pixels over a single OBI manager port,
// streams them to the conv pipeline and writes buffered results back on the same port.
module cnn_frame_sequencer #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int OUT_COUNT  = 676,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] input_base_i,
  input  logic [ADDR_WIDTH-1:0] output_base_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  pix_valid_o,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  input  logic                  res_valid_i,
  input  logic [DATA_WIDTH-1:0] res_data_i,
  output logic                  res_ready_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int PIX_W = $clog2(TOTAL + 1);
  localparam int WR_W  = $clog2(OUT_COUNT + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WB_REQ  = 3'd4,
    S_WB_WAIT = 3'd5,
    S_FIN     = 3'd6
  } state_e;

  state_e                state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] in_base_r, out_base_r;
  logic [PIX_W-1:0]      pix_cnt_r;
  logic [WR_W-1:0]       wr_cnt_r;
  logic                  err_r;
  logic                  pix_valid_r;
  logic [DATA_WIDTH-1:0] pix_data_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]      fifo_cnt_r;

  logic start_acc_s, fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic rd_ok_s, wr_ok_s, bus_err_s, ovf_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s;
  logic unused_s;

  assign unused_s     = ^mem_rdata_i[31:DATA_WIDTH];
  assign start_acc_s  = (state_r == S_IDLE) && start_i;
  assign fifo_full_s  = (fifo_cnt_r == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_s = (fifo_cnt_r == CNT_W'(0));
  assign push_s       = res_valid_i && !fifo_full_s;
  assign pop_s        = (state_r == S_WB_REQ) && mem_gnt_i && !fifo_empty_s;
  assign ovf_s        = res_valid_i && fifo_full_s;
  assign rd_ok_s      = (state_r == S_RD_WAIT) && mem_rvalid_i && !mem_err_i;
  assign wr_ok_s      = (state_r == S_WB_WAIT) && mem_rvalid_i && !mem_err_i;
  assign bus_err_s    = ((state_r == S_RD_WAIT) || (state_r == S_WB_WAIT)) && mem_rvalid_i && mem_err_i;
  assign rd_addr_s    = in_base_r + ADDR_WIDTH'({pix_cnt_r, 2'b00});
  assign wr_addr_s    = out_base_r + ADDR_WIDTH'({wr_cnt_r, 2'b00});

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; writes are gated once the frame's quota is met so surplus results stay buffered
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) state_next_s = S_ARB;
        else         state_next_s = S_IDLE;
      end
      S_ARB: begin
        if (!fifo_empty_s && (wr_cnt_r < WR_W'(OUT_COUNT)))
          state_next_s = S_WB_REQ;
        else if ((pix_cnt_r < PIX_W'(TOTAL)) && (fifo_cnt_r < CNT_W'(FIFO_DEPTH - 1)))
          state_next_s = S_RD_REQ;
        else if ((pix_cnt_r == PIX_W'(TOTAL)) && (wr_cnt_r == WR_W'(OUT_COUNT)))
          state_next_s = S_FIN;
        else
          state_next_s = S_ARB;
      end
      S_RD_REQ: begin
        if (mem_gnt_i) state_next_s = S_RD_WAIT;
        else           state_next_s = S_RD_REQ;
      end
      S_RD_WAIT: begin
        if (mem_rvalid_i) state_next_s = mem_err_i ? S_FIN : S_ARB;
        else              state_next_s = S_RD_WAIT;
      end
      S_WB_REQ: begin
        if (mem_gnt_i) state_next_s = S_WB_WAIT;
        else           state_next_s = S_WB_REQ;
      end
      S_WB_WAIT: begin
        if (mem_rvalid_i) state_next_s = mem_err_i ? S_FIN : S_ARB;
        else              state_next_s = S_WB_WAIT;
      end
      S_FIN:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Base latches and frame counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_base_r  <= '0;
      out_base_r <= '0;
      pix_cnt_r  <= '0;
      wr_cnt_r   <= '0;
    end else if (start_acc_s) begin
      in_base_r  <= input_base_i;
      out_base_r <= output_base_i;
      pix_cnt_r  <= '0;
      wr_cnt_r   <= '0;
    end else begin
      if (rd_ok_s) pix_cnt_r <= pix_cnt_r + PIX_W'(1);
      else         pix_cnt_r <= pix_cnt_r;
      if (wr_ok_s) wr_cnt_r <= wr_cnt_r + WR_W'(1);
      else         wr_cnt_r <= wr_cnt_r;
    end
  end

  // Sticky error: bus error or result overflow, cleared by an accepted start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (start_acc_s) begin
      err_r <= 1'b0;
    end else if (bus_err_s || ovf_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Pixel strobe to the line buffer, one cycle per good read beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_valid_r <= 1'b0;
      pix_data_r  <= '0;
    end else begin
      pix_valid_r <= rd_ok_s;
      if (rd_ok_s) pix_data_r <= mem_rdata_i[DATA_WIDTH-1:0];
      else         pix_data_r <= pix_data_r;
    end
  end

  // Result FIFO; a start flushes it, taking priority over a coincident push
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else if (start_acc_s) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= res_data_i;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      else       rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Output decode from the state register; request fields hold steady until granted
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0000_0000;
    case (state_r)
      S_IDLE: busy_o = 1'b0;
      S_RD_REQ: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = rd_addr_s;
      end
      S_WB_REQ: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wr_addr_s;
        mem_wdata_o = 32'(fifo_mem_r[rd_ptr_r]);
      end
      S_FIN:   done_o = 1'b1;
      default: busy_o = 1'b1;
    endcase
  end

  assign err_o       = err_r;
  assign pix_valid_o = pix_valid_r;
  assign pix_data_o  = pix_data_r;
  assign res_ready_o = !fifo_full_s;
  assign mem_be_o    = 4'hF;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed-plus-random bench for cnn_frame_sequencer on a 4x4 image with a
// reactive OBI memory and a transaction-level reference model.
module tb_cnn_frame_sequencer;

  localparam int TOTAL     = 16;
  localparam int OUT_COUNT = 4;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] in_base = 32'h0, out_base = 32'h0;
  logic        busy, done, err, pix_valid, res_ready;
  logic [7:0]  pix_data;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = 8'h00;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  cnn_frame_sequencer #(
    .IMG_W(4), .IMG_H(4), .OUT_COUNT(OUT_COUNT), .DATA_WIDTH(8), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .input_base_i(in_base), .output_base_i(out_base),
    .busy_o(busy), .done_o(done), .err_o(err), .pix_valid_o(pix_valid), .pix_data_o(pix_data),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          vectors = 0, miscompares = 0;
  txn_t        txn_q[$];
  logic [7:0]  pix_q[$];
  logic [7:0]  exp_wr_q[$];
  logic [31:0] pix_mem [TOTAL];
  logic [31:0] cur_in_base = 32'h0;
  int          thr [5];
  int          done_pulses = 0, wr_grants = 0, wr_settled = 0, accepted = 0;
  bit          block_wr = 1'b0, pending = 1'b0, pend_we = 1'b0;
  int          first_gnt_wait = 0, gnt_max = 0, rv_max = 0, rv_force = -1, err_at_read = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit model_ready();
    return (accepted - wr_settled) < DEPTH;
  endfunction

  // OBI memory: random grant/response latency, write blocking and read error injection
  initial begin : responder
    int gw, rw, idx;
    bit holding;
    logic [31:0] held_addr;
    logic held_we;
    gw = 0; rw = 0; idx = 0; holding = 1'b0; held_addr = 32'h0; held_we = 1'b0;
    forever begin
      @(negedge clk);
      wr_settled = wr_grants;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
      if (rst) begin
        pending = 1'b0;
        holding = 1'b0;
      end else if (pending) begin
        if (rw > 0) rw--;
        else begin
          mem_rvalid = 1'b1;
          pending = 1'b0;
          if (!pend_we) begin
            mem_rdata = (idx >= 0 && idx < TOTAL) ? pix_mem[idx] : 32'hxxxx_xxxx;
            mem_err = (idx == err_at_read);
          end else begin
            mem_rdata = $urandom;
          end
        end
      end else if (mem_req) begin
        if (holding) begin
          check("req_addr_stable", mem_addr, held_addr);
          check("req_we_stable", {31'd0, mem_we}, {31'd0, held_we});
        end else begin
          holding = 1'b1;
          held_addr = mem_addr;
          held_we = mem_we;
          gw = (first_gnt_wait > 0) ? first_gnt_wait : $urandom_range(gnt_max, 0);
          first_gnt_wait = 0;
        end
        if (gw == 0 && !(block_wr && mem_we)) begin
          mem_gnt = 1'b1;
          holding = 1'b0;
          pending = 1'b1;
          pend_we = mem_we;
          txn_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
          if (mem_we) wr_grants++;
          idx = int'((mem_addr - cur_in_base) >> 2);
          rw = (rv_force >= 0) ? rv_force : $urandom_range(rv_max, 0);
        end else if (gw > 0) begin
          gw--;
        end
      end else if (holding) begin
        check("req_dropped_before_gnt", {31'd0, mem_req}, 32'd1);
        holding = 1'b0;
      end
    end
  end

  // Pixel stream and done-pulse monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pix_valid) pix_q.push_back(pix_data);
        if (done) begin
          done_pulses++;
          check("busy_low_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] ib, input logic [31:0] ob);
    for (int i = 0; i < TOTAL; i++) pix_mem[i] = $urandom;
    txn_q.delete(); pix_q.delete(); exp_wr_q.delete();
    accepted = 0; wr_grants = 0; wr_settled = 0; done_pulses = 0;
    cur_in_base = ib;
    in_base = ib; out_base = ob; start = 1'b1;
    tick();
    start = 1'b0; in_base = $urandom; out_base = $urandom;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("err_cleared_by_start", {31'd0, err}, 32'd0);
  endtask

  task automatic push(input logic [7:0] d);
    bit rdy;
    rdy = model_ready();
    check("res_ready", {31'd0, res_ready}, {31'd0, rdy});
    res_valid = 1'b1; res_data = d;
    if (rdy) begin
      accepted++;
      if (exp_wr_q.size() < OUT_COUNT) exp_wr_q.push_back(d);
    end
    tick();
    res_valid = 1'b0;
  endtask

  task automatic run_frame(input int npush, input int limit);
    int k, cyc;
    k = 0; cyc = 0;
    while (done_pulses == 0 && cyc < limit) begin
      if (k < npush && pix_q.size() >= thr[k] && model_ready()) begin
        push(8'($urandom));
        k++;
      end else begin
        tick();
      end
      cyc++;
    end
    check("frame_done_in_time", {31'd0, done_pulses != 0}, 32'd1);
  endtask

  task automatic check_frame(input logic [31:0] ib, input logic [31:0] ob, input int nreads,
                             input int npix, input bit err_exp);
    int nr, nw;
    nr = 0; nw = 0;
    repeat (3) tick();
    check("done_pulse_count", done_pulses, 32'd1);
    check("err_at_end", {31'd0, err}, {31'd0, err_exp});
    check("busy_at_end", {31'd0, busy}, 32'd0);
    foreach (txn_q[i]) begin
      if (!txn_q[i].we) begin
        check("rd_addr", txn_q[i].addr, ib + 32'(4 * nr));
        nr++;
      end else begin
        check("wr_addr", txn_q[i].addr, ob + 32'(4 * nw));
        if (nw < exp_wr_q.size()) check("wr_data", txn_q[i].wdata, {24'd0, exp_wr_q[nw]});
        nw++;
      end
    end
    check("n_reads", nr, nreads);
    check("n_writes", nw, exp_wr_q.size());
    check("n_pixels", pix_q.size(), npix);
    for (int i = 0; i < npix && i < pix_q.size(); i++) check("pix_data", {24'd0, pix_q[i]}, {24'd0, pix_mem[i][7:0]});
  endtask

  initial begin : stimulus
    int fw, lr, cyc, npix_now;
    logic [31:0] ib, ob;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_data", {24'd0, pix_data}, 32'd0);
    check("rst_res_ready", {31'd0, res_ready}, 32'd1);
    check("rst_req", {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'h0000_000F);

    // Zero-wait frame; a result arriving mid-fetch preempts the remaining reads
    thr = '{6, 9, 12, 16, 99};
    do_start(32'h0000_0100, 32'h0000_0200);
    run_frame(4, 2000);
    check_frame(32'h0000_0100, 32'h0000_0200, 16, 16, 1'b0);
    fw = -1; lr = -1;
    foreach (txn_q[i]) begin
      if (txn_q[i].we && fw < 0) fw = i;
      if (!txn_q[i].we) lr = i;
    end
    check("write_before_reads_resume", {31'd0, (fw >= 0) && (fw < lr)}, 32'd1);

    // Reset while a read response is outstanding
    rv_force = 3;
    do_start(32'h0000_0400, 32'h0000_0500);
    cyc = 0;
    while (!(pending && !pend_we) && cyc < 50) begin tick(); cyc++; end
    check("reached_rd_wait", {31'd0, pending && !pend_we}, 32'd1);
    tick();
    #1 rst = 1'b1;
    #1;
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("midrst_no_done_pulse", done_pulses, 32'd0);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);
    rv_force = -1;

    // Random latencies and bases; first read grant held off 5 cycles; one surplus result
    gnt_max = 3; rv_max = 2; first_gnt_wait = 5;
    for (int i = 0; i < 5; i++) thr[i] = $urandom_range(16, 0);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (thr[j] > thr[j+1]) begin cyc = thr[j]; thr[j] = thr[j+1]; thr[j+1] = cyc; end
    ib = $urandom & 32'hFFFF_FFFC;
    ob = $urandom & 32'hFFFF_FFFC;
    do_start(ib, ob);
    run_frame(5, 3000);
    check_frame(ib, ob, 16, 16, 1'b0);

    // Full FIFO with an ungranted write: overflow drops data, flags err, fetch stalls
    gnt_max = 0; rv_max = 0;
    do_start(32'h0000_0600, 32'h0000_0700);
    cyc = 0;
    while (pix_q.size() < 2 && cyc < 100) begin tick(); cyc++; end
    block_wr = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    repeat (3) tick();
    check("full_err_before_ovf", {31'd0, err}, 32'd0);
    check("full_write_pending", {30'd0, mem_req, mem_we}, 32'd3);
    npix_now = pix_q.size();
    push(8'($urandom));
    check("ovf_err", {31'd0, err}, 32'd1);
    repeat (5) tick();
    check("fetch_stalled", pix_q.size(), npix_now);
    block_wr = 1'b0;
    run_frame(0, 2000);
    check_frame(32'h0000_0600, 32'h0000_0700, 16, 16, 1'b1);

    // Bus error on the third read; a start while busy is ignored
    gnt_max = 2; rv_max = 1; err_at_read = 2;
    do_start(32'h0000_0300, 32'h0000_0380);
    in_base = 32'h0000_0900; out_base = 32'h0000_0A00; start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(0, 500);
    check_frame(32'h0000_0300, 32'h0000_0380, 3, 2, 1'b1);
    err_at_read = -1;

    // Next start clears err; normal frame after the error
    thr = '{2, 4, 8, 12, 99};
    do_start(32'h0000_1000, 32'h0000_2000);
    run_frame(4, 3000);
    check_frame(32'h0000_1000, 32'h0000_2000, 16, 16, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
